logic_op_seq32: RTL and testbench

- Multi-cycle sequencer that drives one shared 32-bit 2-input logic unit (AND / OR / NOR / INV function select) to produce both primitive and compound bitwise results.
- Compound ops (NAND, XOR, XNOR, ANDN) are built as one logic-unit step per clock, with intermediates held in two scratch registers T and U.
- Sits beside the ALU as the bitwise-op execution path; the control unit issues START and waits for DONE.

---
 rtl/logic_op_seq32.sv | 189 ++++++++++++++++++
 tb/tb_logic_op_seq32.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_seq32.sv
// Multi-cycle bitwise sequencer: one shared AND/OR/NOR/INV unit builds NAND/XOR/XNOR/ANDN over 1-3 steps.
// Optional op counter output OP_CNT is enabled by defining LOGIC_OP_SEQ_OPCNT_EN.
module logic_op_seq32 #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       OPCODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
`ifdef LOGIC_OP_SEQ_OPCNT_EN
  output logic [15:0]      OP_CNT,
`endif
  output logic [WIDTH-1:0] Y
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STEP1 = 2'd1;
  localparam logic [1:0] S_STEP2 = 2'd2;
  localparam logic [1:0] S_STEP3 = 2'd3;

  localparam logic [1:0] F_AND = 2'd0;
  localparam logic [1:0] F_OR  = 2'd1;
  localparam logic [1:0] F_NOR = 2'd2;
  localparam logic [1:0] F_INV = 2'd3;

  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_T = 2'd2;
  localparam logic [1:0] SRC_U = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] t_q, t_d, u_q, u_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             done_q, done_d;

  logic [1:0]       func;
  logic [1:0]       x_sel, z_sel;
  logic             last_step;
  logic             dst_u;
  logic [WIDTH-1:0] x_opnd, z_opnd, lu_out;

  // Step microcode: what the logic unit does in each STEP state for the latched opcode.
  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    func      = F_AND;
    x_sel     = SRC_A;
    z_sel     = SRC_B;
    last_step = 1'b1;
    dst_u     = 1'b0;
    unique case (op_q)
      3'd0: func = F_AND;
      3'd1: func = F_OR;
      3'd2: func = F_NOR;
      3'd3: func = F_INV;
      3'd4: begin
        if (state_q == S_STEP1) begin
          last_step = 1'b0;
        end else begin
          func  = F_INV;
          x_sel = SRC_T;
        end
      end
      3'd5, 3'd6: begin
        unique case (state_q)
          S_STEP1: last_step = 1'b0;
          S_STEP2: begin
            func      = F_NOR;
            last_step = 1'b0;
            dst_u     = 1'b1;
          end
          default: begin
            func  = (op_q == 3'd5) ? F_NOR : F_OR;
            x_sel = SRC_T;
            z_sel = SRC_U;
          end
        endcase
      end
      default: begin
        if (state_q == S_STEP1) begin
          func      = F_INV;
          x_sel     = SRC_B;
          last_step = 1'b0;
        end else begin
          z_sel = SRC_T;
        end
      end
    endcase
  end

  always_comb begin
    unique case (x_sel)
      SRC_A:   x_opnd = a_q;
      SRC_B:   x_opnd = b_q;
      SRC_T:   x_opnd = t_q;
      default: x_opnd = u_q;
    endcase
    unique case (z_sel)
      SRC_A:   z_opnd = a_q;
      SRC_B:   z_opnd = b_q;
      SRC_T:   z_opnd = t_q;
      default: z_opnd = u_q;
    endcase
    unique case (func)
      F_AND:   lu_out = x_opnd & z_opnd;
      F_OR:    lu_out = x_opnd | z_opnd;
      F_NOR:   lu_out = ~(x_opnd | z_opnd);
      default: lu_out = ~x_opnd;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    t_d     = t_q;
    u_d     = u_q;
    y_d     = y_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (START) begin
        op_d    = OPCODE;
        a_d     = A;
        b_d     = B;
        state_d = S_STEP1;
      end
    end else if (last_step) begin
      y_d     = lu_out;
      done_d  = 1'b1;
      state_d = S_IDLE;
    end else begin
      if (dst_u) u_d = lu_out;
      else       t_d = lu_out;
      state_d = (state_q == S_STEP1) ? S_STEP2 : S_STEP3;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // Operands and scratch registers are cleared too: they are plain flops, not a memory.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
      u_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t_q     <= t_d;
      u_q     <= u_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

`ifdef LOGIC_OP_SEQ_OPCNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts completion edges only; wraps naturally at 16 bits.
  always_comb begin
    cnt_d = cnt_q;
    if (done_d) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign OP_CNT = cnt_q;
`endif

  assign BUSY = (state_q != S_IDLE);
  assign DONE = done_q;
  assign Y    = y_q;

endmodule

// File: tb/tb_logic_op_seq32.sv
// Self-checking bench for logic_op_seq32: directed and random ops against a truth-table reference model.
// Exercises OP_CNT as well when LOGIC_OP_SEQ_OPCNT_EN is defined.
module tb_logic_op_seq32;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [2:0]  OPCODE;
  logic [31:0] A, B;
  logic        BUSY, DONE;
  logic [31:0] Y;
`ifdef LOGIC_OP_SEQ_OPCNT_EN
  logic [15:0] OP_CNT;
`endif

  int checks = 0;
  int errors = 0;

  logic_op_seq32 #(.WIDTH(32)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .OPCODE (OPCODE),
    .A      (A),
    .B      (B),
    .BUSY   (BUSY),
    .DONE   (DONE),
`ifdef LOGIC_OP_SEQ_OPCNT_EN
    .OP_CNT (OP_CNT),
`endif
    .Y      (Y)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ref_y(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a | b);
      3'd3:    return ~a;
      3'd4:    return ~(a & b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return a & ~b;
    endcase
  endfunction

  function automatic int ref_n(input logic [2:0] op);
    case (op)
      3'd4, 3'd7: return 2;
      3'd5, 3'd6: return 3;
      default:    return 1;
    endcase
  endfunction

  // Called #1 after a rising edge with START low (or in a DONE cycle); issues one op and checks it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit pulse_mid, input bit tail, input string name);
    logic [31:0] exp_y, y_before;
    int          n_exp, n_busy;
    bit          got, y_moved;
`ifdef LOGIC_OP_SEQ_OPCNT_EN
    logic [15:0] cnt_before;
    cnt_before = OP_CNT;
`endif
    exp_y    = ref_y(op, a, b);
    n_exp    = ref_n(op);
    y_before = Y;
    got      = 1'b0;
    y_moved  = 1'b0;
    n_busy   = 0;
    START = 1'b1; OPCODE = op; A = a; B = b;
    @(posedge CLK); #1;
    START = 1'b0; OPCODE = 3'($urandom); A = $urandom; B = $urandom;
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: BUSY=%b want 1", name, BUSY);
    end
    for (int i = 0; i < 8; i++) begin
      if (DONE === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (BUSY === 1'b1) n_busy++;
      if (Y !== y_before) y_moved = 1'b1;
      if (pulse_mid && i == 0) begin
        START = 1'b1; OPCODE = 3'd0; A = '0; B = '0;
      end
      if (pulse_mid && i == 1) START = 1'b0;
      @(posedge CLK); #1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done_timeout: no DONE within 8 cycles", name);
    end
    checks++;
    if (n_busy != n_exp) begin
      errors++;
      $display("FAIL %s latency: busy_cycles=%0d want %0d", name, n_busy, n_exp);
    end
    checks++;
    if (Y !== exp_y) begin
      errors++;
      $display("FAIL %s result: Y=%h want %h", name, Y, exp_y);
    end
    checks++;
    if (BUSY !== 1'b0 || y_moved) begin
      errors++;
      $display("FAIL %s busy_done_or_y_held: BUSY=%b y_moved=%b want 0/0", name, BUSY, y_moved);
    end
`ifdef LOGIC_OP_SEQ_OPCNT_EN
    checks++;
    if (OP_CNT !== cnt_before + 16'd1) begin
      errors++;
      $display("FAIL %s opcnt: OP_CNT=%h want %h", name, OP_CNT, cnt_before + 16'd1);
    end
`endif
    if (tail) begin
      @(posedge CLK); #1;
      checks++;
      if (DONE !== 1'b0 || Y !== exp_y) begin
        errors++;
        $display("FAIL %s done_pulse: DONE=%b Y=%h want 0 %h", name, DONE, Y, exp_y);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; START = 1'b0; OPCODE = '0; A = '0; B = '0;
    #2;
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || Y !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: BUSY=%b DONE=%b Y=%h want 0 0 0", BUSY, DONE, Y);
    end
    #10 RST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_primitives();
    run_op(3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b1, "and");
    run_op(3'd1, 32'h0F0F0000, 32'h000000F1, 1'b0, 1'b1, "or");
    run_op(3'd2, 32'h0F0F0000, 32'h000000F1, 1'b0, 1'b1, "nor");
    run_op(3'd3, 32'h00FF00FF, 32'h12345678, 1'b0, 1'b1, "inv");
  endtask

  task automatic test_compound();
    run_op(3'd5, 32'hAAAA5555, 32'hFFFF0000, 1'b0, 1'b1, "xor");
    run_op(3'd6, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, "xnor");
    run_op(3'd4, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 1'b1, "nand");
    run_op(3'd7, 32'h12345678, 32'h0000FFFF, 1'b0, 1'b1, "andn");
  endtask

  task automatic test_ignored_start();
    run_op(3'd5, 32'h13579BDF, 32'h2468ACE0, 1'b1, 1'b1, "xor_ignore_start");
  endtask

  task automatic test_back_to_back();
    run_op(3'd6, 32'hCAFEF00D, 32'h0BADBEEF, 1'b0, 1'b0, "b2b_first");
    run_op(3'd7, 32'hFFFF1234, 32'h00FF00FF, 1'b0, 1'b0, "b2b_second");
    run_op(3'd0, 32'h89ABCDEF, 32'hFFFF0000, 1'b0, 1'b1, "b2b_third");
  endtask

  task automatic test_abort();
    logic        done_seen, y_nonzero;
`ifdef LOGIC_OP_SEQ_OPCNT_EN
    logic [15:0] cnt_before;
    cnt_before = OP_CNT;
`endif
    run_op(3'd1, 32'h80000001, 32'h00000100, 1'b0, 1'b1, "pre_abort");
    START = 1'b1; OPCODE = 3'd5; A = 32'h5A5A5A5A; B = 32'h0F0F0F0F;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || Y !== 32'h0) begin
      errors++;
      $display("FAIL abort_async: BUSY=%b DONE=%b Y=%h want 0 0 0", BUSY, DONE, Y);
    end
    #3 RST = 1'b1;
    done_seen = 1'b0;
    y_nonzero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1) done_seen = 1'b1;
      if (Y !== 32'h0) y_nonzero = 1'b1;
    end
    checks++;
    if (done_seen || y_nonzero || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: done_seen=%b y_nonzero=%b BUSY=%b want 0 0 0", done_seen, y_nonzero, BUSY);
    end
`ifdef LOGIC_OP_SEQ_OPCNT_EN
    checks++;
    if (OP_CNT !== 16'h0) begin
      errors++;
      $display("FAIL abort_opcnt: OP_CNT=%h want 0 (was %h)", OP_CNT, cnt_before);
    end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      run_op(3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0, (k % 3) != 0, "random");
    end
    @(posedge CLK); #1;
  endtask

`ifdef LOGIC_OP_SEQ_OPCNT_EN
  task automatic test_opcnt_wrap();
    bit reached;
    reached = 1'b0;
    START = 1'b1; OPCODE = 3'd0; A = 32'h1; B = 32'h1;
    for (int i = 0; i < 140000; i++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1 && OP_CNT === 16'hFFFF) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL opcnt_preload: OP_CNT=%h never reached FFFF", OP_CNT);
    end
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (DONE !== 1'b1 || OP_CNT !== 16'h0) begin
      errors++;
      $display("FAIL opcnt_wrap: DONE=%b OP_CNT=%h want 1 0000", DONE, OP_CNT);
    end
    @(posedge CLK); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_primitives();
    test_compound();
    test_ignored_start();
    test_back_to_back();
    test_random();
    test_abort();
`ifdef LOGIC_OP_SEQ_OPCNT_EN
    test_opcnt_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
